// File: rtl/comb_restorer_if.sv
// Sample-stream bundle for comb_restorer: input handshake (data_i/valid_i/ready_o)
// and output handshake (data_o/valid_o/ready_i); master is the stream environment.
interface comb_restorer_if #(
  parameter int IO_WIDTH = 16
);
  logic [IO_WIDTH-1:0] data_i;
  logic                valid_i;
  logic                ready_o;
  logic [IO_WIDTH-1:0] data_o;
  logic                valid_o;
  logic                ready_i;

  modport master (output data_i, valid_i, ready_i, input ready_o, data_o, valid_o);
  modport slave  (input data_i, valid_i, ready_i, output ready_o, data_o, valid_o);
endinterface

// File: rtl/comb_restorer.sv
// Comb restorer: out = sat(G * sat(x + K*w[n-D])) using one shared multiplier.
// Optional sticky saturation flag ovf_o when COMB_RESTORER_OVF_FLAG_EN is defined.
module comb_restorer #(
  parameter int unsigned                 DELAY     = 2,
  parameter int                          IO_WIDTH  = 16,
  parameter int                          INT_WIDTH = 18,
  parameter logic signed [INT_WIDTH-1:0] COEF_FB   = 18'sd131071,
  parameter logic signed [INT_WIDTH-1:0] COEF_GAIN = 18'sd65536
) (
  input  logic clk_i,
  input  logic reset_ni,
`ifdef COMB_RESTORER_OVF_FLAG_EN
  output logic ovf_o,
`endif
  comb_restorer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FB, GAIN, OUT} state_t;

  state_t state, state_nxt;

  logic signed [INT_WIDTH-1:0]   x_q, a_q, y_q;
  logic signed [INT_WIDTH-1:0]   w [DELAY];
  logic signed [INT_WIDTH-1:0]   mul_a, mul_b;
  logic signed [2*INT_WIDTH-1:0] prod;
  logic signed [INT_WIDTH+1:0]   fb_sum, gain_r;
  logic signed [INT_WIDTH-1:0]   fb_sat, gain_sat;
  logic                          fb_clip, gain_clip;
  logic                          accept, shift;
  logic                          unused_bits;

  function automatic logic fits(input logic signed [INT_WIDTH+1:0] v);
    return (&v[INT_WIDTH+1:INT_WIDTH-1]) || !(|v[INT_WIDTH+1:INT_WIDTH-1]);
  endfunction

  function automatic logic signed [INT_WIDTH-1:0] sat(input logic signed [INT_WIDTH+1:0] v);
    if (fits(v)) return v[INT_WIDTH-1:0];
    else if (v[INT_WIDTH+1]) return {1'b1, {(INT_WIDTH-1){1'b0}}};
    else return {1'b0, {(INT_WIDTH-1){1'b1}}};
  endfunction

  // Single multiplier: feedback product in FB, gain product in GAIN.
  always_comb begin
    mul_a = COEF_FB;
    mul_b = w[DELAY-1];
    if (state == GAIN) begin
      mul_a = COEF_GAIN;
      mul_b = a_q;
    end
  end

  assign prod = mul_a * mul_b;

  // Bit slices of the product are exact floor shifts (>>> INT_WIDTH-1 and >>> INT_WIDTH-2).
  assign fb_sum    = {{2{x_q[INT_WIDTH-1]}}, x_q} + {prod[2*INT_WIDTH-1], prod[2*INT_WIDTH-1:INT_WIDTH-1]};
  assign gain_r    = prod[2*INT_WIDTH-1:INT_WIDTH-2];
  assign fb_sat    = sat(fb_sum);
  assign gain_sat  = sat(gain_r);
  assign fb_clip   = !fits(fb_sum);
  assign gain_clip = !fits(gain_r);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: if (bus.valid_i) begin
        accept    = 1'b1;
        state_nxt = FB;
      end
      FB:   state_nxt = GAIN;
      GAIN: state_nxt = OUT;
      OUT:  if (bus.ready_i) begin
        shift     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
      x_q   <= '0;
      a_q   <= '0;
      y_q   <= '0;
      for (int unsigned k = 0; k < DELAY; k++) w[k] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) x_q <= {bus.data_i, {(INT_WIDTH-IO_WIDTH){1'b0}}};
      if (state == FB) a_q <= fb_sat;
      if (state == GAIN) y_q <= gain_sat;
      // History advances only on the output handshake so a stall cannot disturb it.
      if (shift) begin
        w[0] <= a_q;
        for (int unsigned k = 1; k < DELAY; k++) w[k] <= w[k-1];
      end
    end
  end

  assign bus.ready_o = (state == IDLE);
  assign bus.valid_o = (state == OUT);
  assign bus.data_o  = y_q[INT_WIDTH-1 -: IO_WIDTH];

  assign unused_bits = ^{prod[INT_WIDTH-3:0], y_q[INT_WIDTH-IO_WIDTH-1:0]};

`ifdef COMB_RESTORER_OVF_FLAG_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) ovf_o <= 1'b0;
    else if ((state == FB && fb_clip) || (state == GAIN && gain_clip)) ovf_o <= 1'b1;
  end
`else
  logic unused_clip;
  assign unused_clip = fb_clip ^ gain_clip;
`endif

endmodule
